// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key schedule: length codes, Nk/Nr lookup,
// GF(2^8) doubling and controller state encodings.
package aes_key_pkg;

  localparam logic [1:0] LEN_128  = 2'b00;
  localparam logic [1:0] LEN_192  = 2'b01;
  localparam logic [1:0] LEN_256  = 2'b10;
  localparam logic [1:0] LEN_RSVD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [8:0] AES_POLY  = 9'h11B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      LEN_128: return 4'd4;
      LEN_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      LEN_128: return 4'd10;
      LEN_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [8:0] s;
    s = {b, 1'b0};
    if (s[8]) s = s ^ AES_POLY;
    return s[7:0];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map,
// avoiding a 256-entry table per instance.
module aes_sbox
  import aes_key_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int n = 0; n < 8; n++) begin
      if (y[n]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 via an addition chain; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_f(a);

endmodule

// File: rtl/key_word_gen.sv
// Combinational next-word logic: w_new = w_back ^ t, where t is the previous
// word optionally rotated, substituted and mixed with rcon.
module key_word_gen (
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [7:0]  rcon,
  input  logic        sel_rot_sub,
  input  logic        sel_sub,
  output logic [31:0] w_new
);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;

  assign sub_in = sel_rot_sub ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .a(sub_in[8*gi +: 8]),
        .s(sub_out[8*gi +: 8])
      );
    end
  endgenerate

  assign t = sel_rot_sub ? (sub_out ^ {rcon, 24'h000000}) :
             sel_sub     ? sub_out : w_prev;

  assign w_new = w_back ^ t;

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128/192/256 key schedule: one word per cycle into an 8-word
// sliding window, round keys written out as soon as their last word exists.
module key_schedule_ctrl
  import aes_key_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in_valid,
  output logic              key_in_ready,
  input  logic [1:0]        key_in_len,
  input  logic [255:0]      key_in,
  output logic [127:0]      key_out,
  output logic [ADDR_W-1:0] key_addr,
  output logic              key_we,
  output logic              key_loaded,
  output logic [3:0]        num_rounds,
  output logic              key_err
);

  state_t              state_reg;
  logic [31:0]         win_reg [8];
  logic [5:0]          i_reg;
  logic [2:0]          phase_reg;
  logic [7:0]          rcon_reg;
  logic [3:0]          nk_reg;
  logic [3:0]          nr_reg;
  logic [5:0]          total_reg;
  logic [3:0]          k_next_reg;
  logic                last_reg;
  logic                key_we_reg;
  logic [ADDR_W-1:0]   key_addr_reg;
  logic [127:0]        key_out_reg;
  logic                key_loaded_reg;
  logic                key_err_reg;

  logic                accept;
  logic                len_ok;
  logic [3:0]          nk_in;
  logic [3:0]          nr_in;
  logic [5:0]          total_in;
  logic [31:0]         kw [8];
  logic [31:0]         load_win [8];
  logic                gen_active;
  logic                sel_rot_sub;
  logic                sel_sub;
  logic [31:0]         w_back;
  logic [31:0]         w_new;
  logic [5:0]          emit_pos;
  logic                emit;
  logic [127:0]        emit_data;

  assign key_in_ready = (state_reg != ST_EXPAND);
  assign accept       = key_in_valid & key_in_ready;
  assign len_ok       = (key_in_len != LEN_RSVD) && (ENABLE_256 || key_in_len == LEN_128);
  assign nk_in        = nk_of(key_in_len);
  assign nr_in        = nr_of(key_in_len);
  assign total_in     = {nr_in + 4'd1, 2'b00};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_kw
      assign kw[gi] = key_in[255-32*gi -: 32];
    end
  endgenerate

  // Window slot 0 holds the newest word, so the key loads in reverse order
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      load_win[j] = '0;
      if (j < int'(nk_in)) load_win[j] = kw[3'(int'(nk_in) - 1 - j)];
    end
  end

  assign gen_active  = (state_reg == ST_EXPAND) && (i_reg < total_reg);
  assign sel_rot_sub = (phase_reg == 3'd0);
  assign sel_sub     = (nk_reg == 4'd8) && (phase_reg == 3'd4);
  assign w_back      = win_reg[3'(nk_reg - 4'd1)];

  key_word_gen u_word_gen (
    .w_prev      (win_reg[0]),
    .w_back      (w_back),
    .rcon        (rcon_reg),
    .sel_rot_sub (sel_rot_sub),
    .sel_sub     (sel_sub),
    .w_new       (w_new)
  );

  // Round key k is ready once word 4k+3 is being produced or already stored;
  // the stored case only arises for AES-256 RK1, which waits a cycle behind RK0.
  assign emit_pos  = {k_next_reg, 2'b11};
  assign emit      = gen_active && (emit_pos <= i_reg) && (k_next_reg <= nr_reg);
  assign emit_data = (emit_pos != i_reg) ?
                     {win_reg[3], win_reg[2], win_reg[1], win_reg[0]} :
                     {win_reg[2], win_reg[1], win_reg[0], w_new};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      for (int j = 0; j < 8; j++) win_reg[j] <= '0;
      i_reg          <= '0;
      phase_reg      <= '0;
      rcon_reg       <= RCON_INIT;
      nk_reg         <= 4'd4;
      nr_reg         <= '0;
      total_reg      <= '0;
      k_next_reg     <= '0;
      last_reg       <= 1'b0;
      key_we_reg     <= 1'b0;
      key_addr_reg   <= '0;
      key_out_reg    <= '0;
      key_loaded_reg <= 1'b0;
      key_err_reg    <= 1'b0;
    end else begin
      key_we_reg  <= 1'b0;
      key_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            key_loaded_reg <= 1'b0;
            if (len_ok) begin
              state_reg    <= ST_EXPAND;
              for (int j = 0; j < 8; j++) win_reg[j] <= load_win[j];
              i_reg        <= {2'b00, nk_in};
              phase_reg    <= '0;
              rcon_reg     <= RCON_INIT;
              nk_reg       <= nk_in;
              nr_reg       <= nr_in;
              total_reg    <= total_in;
              k_next_reg   <= 4'd1;
              last_reg     <= 1'b0;
              key_we_reg   <= 1'b1;
              key_addr_reg <= '0;
              key_out_reg  <= key_in[255:128];
            end else begin
              state_reg   <= ST_IDLE;
              key_err_reg <= 1'b1;
            end
          end
        end
        ST_EXPAND: begin
          if (gen_active) begin
            win_reg[0] <= w_new;
            for (int j = 1; j < 8; j++) win_reg[j] <= win_reg[j-1];
            i_reg     <= i_reg + 6'd1;
            phase_reg <= (phase_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : phase_reg + 3'd1;
            if (sel_rot_sub) rcon_reg <= xtime(rcon_reg);
          end
          if (emit) begin
            key_we_reg   <= 1'b1;
            key_addr_reg <= ADDR_W'(k_next_reg);
            key_out_reg  <= emit_data;
            k_next_reg   <= k_next_reg + 4'd1;
            if (k_next_reg == nr_reg) last_reg <= 1'b1;
          end
          if (last_reg) begin
            state_reg      <= ST_DONE;
            key_loaded_reg <= 1'b1;
            last_reg       <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign key_out    = key_out_reg;
  assign key_addr   = key_addr_reg;
  assign key_we     = key_we_reg;
  assign key_loaded = key_loaded_reg;
  assign num_rounds = nr_reg;
  assign key_err    = key_err_reg;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 appendix A key vectors.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [1:0]   key_in_len;
  logic [255:0] key_in;
  logic [127:0] key_out;
  logic [3:0]   key_addr;
  logic         key_we;
  logic         key_loaded;
  logic [3:0]   num_rounds;
  logic         key_err;

  logic         v2_valid;
  logic         v2_ready;
  logic [1:0]   v2_len;
  logic [255:0] v2_key;
  logic [127:0] v2_out;
  logic [3:0]   v2_addr;
  logic         v2_we;
  logic         v2_loaded;
  logic [3:0]   v2_nr;
  logic         v2_err;

  always #5 clk = ~clk;

  key_schedule_ctrl #(.ADDR_W(4), .ENABLE_256(1'b1)) u_dut (
    .clk(clk), .rst(rst), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .key_in_len(key_in_len), .key_in(key_in), .key_out(key_out), .key_addr(key_addr),
    .key_we(key_we), .key_loaded(key_loaded), .num_rounds(num_rounds), .key_err(key_err)
  );

  key_schedule_ctrl #(.ADDR_W(4), .ENABLE_256(1'b0)) u_dut128 (
    .clk(clk), .rst(rst), .key_in_valid(v2_valid), .key_in_ready(v2_ready),
    .key_in_len(v2_len), .key_in(v2_key), .key_out(v2_out), .key_addr(v2_addr),
    .key_we(v2_we), .key_loaded(v2_loaded), .num_rounds(v2_nr), .key_err(v2_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           inj_cycle;
    int           nkeys;
    int           loaded;
    logic [3:0]   nr;
  } run_t;

  typedef struct {
    int           run;
    int           addr;
    int           cyc;
    logic [127:0] data;
  } vec_t;

  run_t runs[4];
  vec_t vecs[12];

  int           ev_n;
  int           ev_cyc [16];
  int           ev_addr [16];
  logic [127:0] ev_data [16];
  int           loaded_cyc;
  logic         loaded_c1;
  int           bad_ready;
  logic [3:0]   nr_seen;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic run_key(input logic [1:0] len, input logic [255:0] key, input int inj_cycle);
    ev_n = 0;
    loaded_cyc = -1;
    bad_ready = 0;
    loaded_c1 = 1'bx;
    @(negedge clk);
    key_in_len = len;
    key_in = key;
    key_in_valid = 1'b1;
    check("ready_at_accept", 256'(key_in_ready), 256'd1);
    @(posedge clk);
    #1 key_in_valid = 1'b0;
    for (int c = 1; c <= 80 && loaded_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) loaded_c1 = key_loaded;
      if (c == inj_cycle) begin
        if (key_in_ready) bad_ready++;
        key_in_valid = 1'b1;
        key_in_len = 2'b00;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (c == inj_cycle + 1) key_in_valid = 1'b0;
      if (key_we) begin
        if (ev_n < 16) begin
          ev_cyc[ev_n] = c;
          ev_addr[ev_n] = int'(key_addr);
          ev_data[ev_n] = key_out;
        end
        ev_n++;
      end
      if (key_loaded) loaded_cyc = c;
    end
    key_in_valid = 1'b0;
    nr_seen = num_rounds;
  endtask

  task automatic check_run(input int r);
    int seq_bad;
    int idx;
    seq_bad = 0;
    for (int j = 0; j < 16 && j < ev_n; j++) if (ev_addr[j] != j) seq_bad++;
    check($sformatf("run%0d_we_count", r), 256'(ev_n), 256'(runs[r].nkeys));
    check($sformatf("run%0d_addr_seq", r), 256'(seq_bad), 256'd0);
    check($sformatf("run%0d_loaded_cycle", r), 256'(loaded_cyc), 256'(runs[r].loaded));
    check($sformatf("run%0d_num_rounds", r), 256'(nr_seen), 256'(runs[r].nr));
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].run == r) begin
        idx = -1;
        for (int j = 0; j < 16 && j < ev_n; j++) if (ev_addr[j] == vecs[v].addr) idx = j;
        if (idx < 0) begin
          check($sformatf("run%0d_rk%0d_present", r, vecs[v].addr), 256'd0, 256'd1);
        end else begin
          check($sformatf("run%0d_rk%0d_cycle", r, vecs[v].addr), 256'(ev_cyc[idx]), 256'(vecs[v].cyc));
          check($sformatf("run%0d_rk%0d_data", r, vecs[v].addr), 256'(ev_data[idx]), 256'(vecs[v].data));
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 256'(key_in_ready), 256'd1);
    check({tag, "_we"}, 256'(key_we), 256'd0);
    check({tag, "_loaded"}, 256'(key_loaded), 256'd0);
    check({tag, "_err"}, 256'(key_err), 256'd0);
    check({tag, "_addr"}, 256'(key_addr), 256'd0);
    check({tag, "_out"}, 256'(key_out), 256'd0);
    check({tag, "_nr"}, 256'(num_rounds), 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    int ld_seen;
    runs[0] = '{2'b00, KEY128, 0, 11, 42, 4'd10};
    runs[1] = '{2'b10, KEY256, 10, 15, 54, 4'd14};
    runs[2] = '{2'b01, KEY192, 0, 13, 48, 4'd12};
    runs[3] = '{2'b00, KEY128, 0, 11, 42, 4'd10};
    vecs[0]  = '{0, 0, 1, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{0, 1, 5, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{0, 10, 41, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3]  = '{1, 0, 1, 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[4]  = '{1, 1, 2, 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[5]  = '{1, 2, 5, 128'h9ba354118e6925afa51a8b5f2067fcde};
    vecs[6]  = '{1, 14, 53, 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[7]  = '{2, 0, 1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[8]  = '{2, 1, 3, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    vecs[9]  = '{2, 12, 47, 128'he98ba06f448c773c8ecc720401002202};
    vecs[10] = '{3, 1, 5, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[11] = '{3, 10, 41, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst = 1'b1;
    key_in_valid = 1'b0; key_in_len = 2'b00; key_in = '0;
    v2_valid = 1'b0; v2_len = 2'b00; v2_key = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reserved length on the full-featured instance
    key_in_len = 2'b11; key_in = KEY256; key_in_valid = 1'b1;
    @(posedge clk); #1 key_in_valid = 1'b0;
    @(negedge clk);
    check("illegal_rsvd_err", 256'(key_err), 256'd1);
    check("illegal_rsvd_we", 256'(key_we), 256'd0);
    check("illegal_rsvd_ready", 256'(key_in_ready), 256'd1);
    @(negedge clk);
    check("illegal_rsvd_err_one_cycle", 256'(key_err), 256'd0);
    check("illegal_rsvd_no_we", 256'(key_we), 256'd0);

    // 256-bit request on the 128-only instance
    v2_len = 2'b10; v2_key = KEY256; v2_valid = 1'b1;
    @(posedge clk); #1 v2_valid = 1'b0;
    @(negedge clk);
    check("illegal_256_err", 256'(v2_err), 256'd1);
    check("illegal_256_we", 256'(v2_we), 256'd0);
    check("illegal_256_ready", 256'(v2_ready), 256'd1);
    @(negedge clk);
    check("illegal_256_err_one_cycle", 256'(v2_err), 256'd0);
    check("illegal_256_nr", 256'(v2_nr), 256'd0);

    run_key(runs[0].len, runs[0].key, runs[0].inj_cycle);
    check_run(0);

    // Rekey straight from DONE, with a stray request mid-expansion
    run_key(runs[1].len, runs[1].key, runs[1].inj_cycle);
    check_run(1);
    check("rekey_loaded_drop_c1", 256'(loaded_c1), 256'd0);
    check("rekey_ready_low_mid_expand", 256'(bad_ready), 256'd0);

    run_key(runs[2].len, runs[2].key, runs[2].inj_cycle);
    check_run(2);

    // Illegal length while DONE drops key_loaded and returns to idle
    @(negedge clk);
    key_in_len = 2'b11; key_in_valid = 1'b1;
    @(posedge clk); #1 key_in_valid = 1'b0;
    @(negedge clk);
    check("done_illegal_err", 256'(key_err), 256'd1);
    check("done_illegal_loaded", 256'(key_loaded), 256'd0);
    check("done_illegal_ready", 256'(key_in_ready), 256'd1);

    // Reset in cycle 20 of an AES-128 expansion
    @(negedge clk);
    key_in_len = 2'b00; key_in = KEY128; key_in_valid = 1'b1;
    @(posedge clk); #1 key_in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 256'(key_in_ready), 256'd0);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    ld_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (key_we) we_seen++;
      if (key_loaded) ld_seen++;
    end
    check("post_reset_no_we", 256'(we_seen), 256'd0);
    check("post_reset_no_loaded", 256'(ld_seen), 256'd0);

    run_key(runs[3].len, runs[3].key, runs[3].inj_cycle);
    check_run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Iterative AES key schedule controller for AES-128, AES-192 and AES-256. It accepts one cipher key per handshake and generates one 32-bit schedule word per cycle. It emits each 128-bit round key with a write strobe and address into the round-key register file. It replaces the fixed 11-round AES-128 sequencer with a length-selectable, handshaked, error-reporting block.

Parameters:
ADDR_W, 4, width of key_addr; must be at least 4.
ENABLE_256, 1, when 0 only AES-128 is legal; 192/256 requests raise key_err.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
key_in_valid  in  1  key request
key_in_ready  out  1  block can accept a key
key_in_len  in  2  00=128, 01=192, 10=256, 11=reserved
key_in  in  256  key, left-aligned: w0=key_in[255:224]; a 128-bit key occupies [255:128]
key_out  out  128  round key {w4k,w4k+1,w4k+2,w4k+3}, w4k in [127:96]
key_addr  out  ADDR_W  round index k, 0..Nr
key_we  out  1  one-cycle strobe; key_out/key_addr valid
key_loaded  out  1  full schedule written
num_rounds  out  4  Nr of the current key (10/12/14)
key_err  out  1  one-cycle pulse on an illegal length

Behaviour:
- Reset values: state IDLE, key_in_ready=1, key_we=0, key_loaded=0, key_err=0, key_addr=0, key_out=0, num_rounds=0.
- Nk/Nr by length: 4/10, 6/12, 8/14. Total words: 44, 52, 60.
- The handshake fires on key_in_valid & key_in_ready; this is cycle 0.
- key_in_ready=1 only in IDLE and DONE. It is 0 throughout EXPAND.
- FSM states:
  - IDLE: on accept with a legal length -> EXPAND.
  - IDLE: on accept with an illegal length -> key_err=1 for one cycle, stay IDLE.
  - EXPAND: after the last key_we -> DONE.
  - DONE: key_loaded=1. On accept with a legal length -> EXPAND and key_loaded=0 from cycle 1. On accept with an illegal length -> IDLE, key_err pulse, key_loaded=0.
- Load (cycle 0 edge): w0..w(Nk-1) go into an 8-word sliding window. Set i=Nk, rcon=0x01, and latch num_rounds.
- Generation: word w_i is produced in cycle i-Nk+1, one per cycle, as w_i = w_(i-Nk) xor t.
  - t = SubWord(RotWord(w_(i-1))) xor {rcon,24'h0} when i mod Nk == 0.
  - t = SubWord(w_(i-1)) when Nk==8 and i mod 8 == 4.
  - Otherwise t = w_(i-1).
- Rcon update after each use: rcon = xtime(rcon), reduced by 0x11B. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- Emission: at most one key_we per cycle. Round key k is emitted in cycle max(4k+5-Nk, k+1).
  - AES-128: RK0 in cycle 1, RK1 in cycle 5, last key in cycle 41.
  - AES-192: RK0 in cycle 1, RK1 in cycle 3, last key in cycle 47.
  - AES-256: RK0 in cycle 1, RK1 in cycle 2, RK2 in cycle 5, last key in cycle 53.
- key_loaded rises in the cycle after the last key_we: cycle 42, 48 or 54.
- key_addr holds its last value when key_we=0. key_out is only meaningful with key_we.
- Generation stops at word 4(Nr+1)-1. No extra words are generated and rcon is not used past the final value.
- Reset mid-EXPAND: all state is cleared immediately. No further key_we is issued. key_loaded stays 0 until a full new schedule completes.
- key_in_valid during EXPAND is ignored because ready is low. The requester must hold valid until accepted.

Decomposition:
- Package aes_key_pkg holds:
  - length encodings LEN_128/192/256/RSVD;
  - functions nk_of(len) and nr_of(len);
  - RCON_INIT=8'h01;
  - xtime() and the 0x11B reduction constant;
  - FSM state encodings.
- Sub-module key_word_gen is combinational. Inputs: w_prev, w_back, rcon, sel_rot_sub, sel_sub. It contains RotWord, four aes_sbox instances and the Rcon/xor logic, and is instantiated once.
- The controller owns the FSM, word counter, window, rcon register and output assembly.

Test Plan:
- AES-128, FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> RK1 = a0fafe17 88542cb1 23a33939 2a6c7605 at cycle 5, addr 1. RK10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 at cycle 41. key_loaded=1 at cycle 42. Exactly 11 key_we pulses.
- AES-192, A.2 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> RK12 = e98ba06f 448c773c 8ecc7204 01002202 at cycle 47, addr 12. num_rounds=12.
- AES-256, A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> RK1 = 1f352c07 3b6108d7 2d9810a3 0914dff4 at cycle 2. RK14 = fe4890d1 e6188d0b 046df344 706c631e at cycle 53.
- Illegal length: key_in_len=11 in IDLE -> key_err high for exactly 1 cycle, no key_we, state IDLE. Repeat with ENABLE_256=0 and len=10 -> same result.
- Rekey from DONE: a 128-bit key completes, then a 256-bit key is accepted -> key_loaded drops at cycle 1, 15 new keys are written, key_loaded returns at cycle 54. key_in_valid asserted mid-EXPAND -> ready=0, no effect.
- Reset at cycle 20 of an AES-128 run -> all outputs take reset values at once. A subsequent A.1 key produces a correct full schedule.
